// File: rtl/v_hier_qvec_pack_if.sv
// Bus bundle between the v_hier_sub result stream and the word consumer.
// Handshake: a word transfers on every rising clk where out_vld & out_rdy;
// out_vld never depends on out_rdy, and out_data/out_cnt hold while out_vld & !out_rdy.
interface v_hier_qvec_pack_if #(
  parameter int NIBBLES = 4,
  parameter int LW      = 3
);
  logic                 qvec_vld;
  logic [3:0]           qvec;
  logic                 flush;
  logic                 out_vld;
  logic                 out_rdy;
  logic [4*NIBBLES-1:0] out_data;
  logic [3:0]           out_cnt;
  logic [LW-1:0]        fifo_level;
  logic                 overflow;
  logic                 clr_ovf;

  // Producer/consumer side (drives nibbles, accepts words).
  modport master (
    output qvec_vld, qvec, flush, out_rdy, clr_ovf,
    input  out_vld, out_data, out_cnt, fifo_level, overflow
  );

  // Packer side.
  modport slave (
    input  qvec_vld, qvec, flush, out_rdy, clr_ovf,
    output out_vld, out_data, out_cnt, fifo_level, overflow
  );
endinterface

// File: rtl/v_hier_qvec_pack.sv
// Packs 4-bit qvec nibbles LSB-first into NIBBLES*4-bit words and queues them
// in a DEPTH-entry FIFO with a sticky overflow flag for dropped words.
module v_hier_qvec_pack #(
  parameter int NIBBLES = 4,
  parameter int DEPTH   = 4,
  parameter int LW      = 3
) (
  input  logic                  clk,
  input  logic                  reset_l,
  v_hier_qvec_pack_if.slave     bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pack stage
  logic [3:0]    pc, pc_nxt;
  logic [W-1:0]  pack_reg, pack_nxt, merged;
  logic [3:0]    push_cnt;
  logic          complete, push;

  // FIFO stage
  logic [W-1:0]  mem_data [DEPTH];
  logic [3:0]    mem_cnt  [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level, level_nxt;
  logic          full, empty, pop, accept, drop;
  logic          ovf;

  // Same-cycle nibble is merged in so completion and flush both see it.
  always_comb begin
    merged = pack_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (bus.qvec_vld && (pc == 4'(i))) merged[4*i +: 4] = bus.qvec;
    end
  end

  always_comb begin
    complete = bus.qvec_vld && (pc == 4'(NIBBLES - 1));
    push     = complete || (bus.flush && ((pc != 4'd0) || bus.qvec_vld));
    push_cnt = pc + {3'd0, bus.qvec_vld};
  end

  // A push always restarts packing, even when the FIFO drops the word.
  always_comb begin
    pc_nxt   = push_cnt;
    pack_nxt = merged;
    if (push) begin
      pc_nxt   = 4'd0;
      pack_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      pc       <= 4'd0;
      pack_reg <= '0;
    end else begin
      pc       <= pc_nxt;
      pack_reg <= pack_nxt;
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    empty  = (level == '0);
    full   = (level == LW'(DEPTH));
    pop    = !empty && bus.out_rdy;
    accept = push && (!full || pop);
    drop   = push && !accept;
  end

  always_comb begin
    level_nxt = level;
    if (accept && !pop)      level_nxt = level + LW'(1);
    else if (pop && !accept) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (accept) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (pop)    rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      level <= level_nxt;
    end
  end

  // Storage needs no reset: contents are only visible through a nonzero level.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wptr] <= merged;
      mem_cnt[wptr]  <= push_cnt;
    end
  end

  // A drop on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)         ovf <= 1'b0;
    else if (drop)        ovf <= 1'b1;
    else if (bus.clr_ovf) ovf <= 1'b0;
  end

  always_comb begin
    bus.out_vld    = !empty;
    bus.out_data   = empty ? '0 : mem_data[rptr];
    bus.out_cnt    = empty ? 4'd0 : mem_cnt[rptr];
    bus.fifo_level = level;
    bus.overflow   = ovf;
  end
endmodule

// File: tb/tb_v_hier_qvec_pack.sv
// Directed bench for v_hier_qvec_pack: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares every word the DUT hands over.
module tb_v_hier_qvec_pack;
  localparam int NIBBLES = 4;
  localparam int DEPTH   = 4;
  localparam int LW      = 3;
  localparam int W       = 4 * NIBBLES;

  logic clk;
  logic reset_l;
  int   checks;
  int   errors;

  logic [W+3:0] exp_q[$];

  v_hier_qvec_pack_if #(.NIBBLES(NIBBLES), .LW(LW)) bus ();

  v_hier_qvec_pack #(.NIBBLES(NIBBLES), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drivers: called at posedge+1, drive one cycle, return at next posedge+1.
  task automatic cyc(input logic v, input logic [3:0] q, input logic f, input logic c = 1'b0);
    bus.qvec_vld = v;
    bus.qvec     = q;
    bus.flush    = f;
    bus.clr_ovf  = c;
    @(posedge clk);
    #1;
    bus.qvec_vld = 1'b0;
    bus.qvec     = 4'd0;
    bus.flush    = 1'b0;
    bus.clr_ovf  = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit expect_push);
    logic [W-1:0] wv;
    wv = w;
    if (expect_push) exp_q.push_back({4'd4, wv});
    for (int i = 0; i < NIBBLES; i++) cyc(1'b1, wv[4*i +: 4], 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_l) begin
      checks++;
      if (bus.fifo_level > LW'(DEPTH)) begin
        errors++;
        $display("FAIL level_bound actual=%0d expected<=%0d", bus.fifo_level, DEPTH);
      end
      if (!bus.out_vld) begin
        checks++;
        if (bus.out_data !== '0 || bus.out_cnt !== 4'd0) begin
          errors++;
          $display("FAIL idle_zero actual=%0h/%0d expected=0/0", bus.out_data, bus.out_cnt);
        end
      end else if (bus.out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual=%0h/%0d expected=none", bus.out_data, bus.out_cnt);
        end else begin
          logic [W+3:0] e;
          e = exp_q.pop_front();
          if ({bus.out_cnt, bus.out_data} !== e) begin
            errors++;
            $display("FAIL word actual=%0d/%0h expected=%0d/%0h",
                     bus.out_cnt, bus.out_data, e[W+3:W], e[W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset_l      = 1'b0;
    bus.qvec_vld = 1'b0;
    bus.qvec     = 4'd0;
    bus.flush    = 1'b0;
    bus.out_rdy  = 1'b0;
    bus.clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld",  bus.out_vld, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_cnt",  bus.out_cnt, 0);
    chk("rst_level",    bus.fifo_level, 0);
    chk("rst_overflow", bus.overflow, 0);
    reset_l = 1'b1;
    @(posedge clk);
    #1;

    // Full word, one-cycle latency to head
    bus.out_rdy = 1'b1;
    exp_q.push_back({4'd4, 16'h4321});
    cyc(1, 4'h1, 0); cyc(1, 4'h2, 0); cyc(1, 4'h3, 0); cyc(1, 4'h4, 0);
    chk("t1_vld_after_push", bus.out_vld, 1);
    @(posedge clk);
    #1;
    chk("t1_vld_after_pop", bus.out_vld, 0);

    // Partial word flush, then flush with nothing pending
    exp_q.push_back({4'd2, 16'h00BA});
    cyc(1, 4'hA, 0); cyc(1, 4'hB, 0); cyc(0, 4'h0, 1);
    chk("t2_vld_after_flush", bus.out_vld, 1);
    cyc(0, 4'h0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_empty_flush", bus.fifo_level, 0);

    // Flush with same-cycle nibble, then a clean following word
    exp_q.push_back({4'd2, 16'h0073});
    cyc(1, 4'h3, 0); cyc(1, 4'h7, 1);
    send_word(16'hBA98, 1);
    wait_drain("t5_drain");

    // Overflow: five words into a four-entry FIFO
    bus.out_rdy = 1'b0;
    send_word(16'h1111, 1);
    send_word(16'h2222, 1);
    send_word(16'h3333, 1);
    send_word(16'h4444, 1);
    chk("t3_level_full", bus.fifo_level, 4);
    chk("t3_no_ovf_yet", bus.overflow, 0);
    send_word(16'h5555, 0);
    chk("t3_level_cap", bus.fifo_level, 4);
    chk("t3_overflow", bus.overflow, 1);
    bus.out_rdy = 1'b1;
    wait_drain("t3_drain");
    chk("t3_ovf_sticky", bus.overflow, 1);
    bus.out_rdy = 1'b0;

    // Mid-word reset with words queued
    send_word(16'h6666, 0);
    send_word(16'h7777, 0);
    cyc(1, 4'h9, 0); cyc(1, 4'h8, 0);
    chk("t6_level_before", bus.fifo_level, 2);
    #2;
    reset_l = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_vld",   bus.out_vld, 0);
    chk("t6_rst_level", bus.fifo_level, 0);
    chk("t6_rst_ovf",   bus.overflow, 0);
    chk("t6_rst_data",  bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_l = 1'b1;
    bus.out_rdy = 1'b1;
    send_word(16'hFEDC, 1);
    wait_drain("t6_drain");

    // Full FIFO with simultaneous pop and push
    bus.out_rdy = 1'b0;
    send_word(16'hA001, 1);
    send_word(16'hA002, 1);
    send_word(16'hA003, 1);
    send_word(16'hA004, 1);
    exp_q.push_back({4'd4, 16'hA005});
    cyc(1, 4'h5, 0); cyc(1, 4'h0, 0); cyc(1, 4'h0, 0);
    bus.out_rdy = 1'b1;
    cyc(1, 4'hA, 0);
    bus.out_rdy = 1'b0;
    chk("t4_level_kept", bus.fifo_level, 4);
    chk("t4_no_ovf", bus.overflow, 0);
    bus.out_rdy = 1'b1;
    wait_drain("t4_drain");

    // Drop coinciding with clr_ovf: set wins; then plain clear
    bus.out_rdy = 1'b0;
    send_word(16'hB001, 1);
    send_word(16'hB002, 1);
    send_word(16'hB003, 1);
    send_word(16'hB004, 1);
    cyc(1, 4'h1, 0); cyc(1, 4'h2, 0); cyc(1, 4'h3, 0);
    cyc(1, 4'h4, 0, 1);
    chk("t7_set_wins", bus.overflow, 1);
    cyc(0, 4'h0, 0, 1);
    chk("t7_clear", bus.overflow, 0);
    bus.out_rdy = 1'b1;
    wait_drain("t7_drain");

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
